// File: rtl/counter_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module   : counter_scheduler_if
//  Purpose  : Signal bundle between the round-robin scheduler, its requesters
//             and the shared Counter busy-timer.
//  Revision : 1.0 - initial release
// ============================================================================
interface counter_scheduler_if #(
    parameter int NREQ = 4
) ();
    localparam int OWNER_W = $clog2(NREQ);

    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    grant;
    logic [NREQ-1:0]    done;
    logic [OWNER_W-1:0] owner;
    logic               owner_valid;
    logic               startSignal__ENA;
    logic               startSignal__RDY;
    logic               busy;
    logic               timeout;
    logic               timeout_clr;

    // Requesters plus the Counter: they drive requests and timer status.
    modport master (
        output req,
        output startSignal__RDY,
        output busy,
        output timeout_clr,
        input  grant,
        input  done,
        input  owner,
        input  owner_valid,
        input  startSignal__ENA,
        input  timeout
    );

    // The scheduler itself.
    modport slave (
        input  req,
        input  startSignal__RDY,
        input  busy,
        input  timeout_clr,
        output grant,
        output done,
        output owner,
        output owner_valid,
        output startSignal__ENA,
        output timeout
    );
endinterface
`default_nettype wire

// File: rtl/counter_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : counter_scheduler
//  Purpose  : Round-robin owner selection for one shared Counter busy-timer.
//             Fires the timer start for the winner, waits for busy to drop,
//             returns a one-cycle done pulse, and flags a timer that never
//             goes idle through a sticky watchdog timeout.
//  Revision : 1.0 - initial release
// ============================================================================
module counter_scheduler #(
    parameter int NREQ     = 4,
    parameter int WATCHDOG = 65535
) (
    input  wire logic             CLK,
    input  wire logic             RST,
    counter_scheduler_if.slave    bus
);

    localparam int IDX_W = $clog2(NREQ);
    localparam int WD_W  = 16;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WATCHDOG - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic              owner_valid_q, owner_valid_d;
    logic              timeout_q, timeout_d;
    logic [WD_W-1:0]   wd_q, wd_d;

    logic              win_found;
    logic [IDX_W-1:0]  win_idx;
    logic [IDX_W:0]    cand;
    logic              start_ena;

    // The start strobe must react to RDY in the same cycle, so it is not registered.
    assign start_ena = (state_q == ST_START) && bus.startSignal__RDY;

    // Search requests upward from the pointer, wrapping at NREQ (works for non power-of-two NREQ).
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = {1'b0, ptr_q} + (IDX_W+1)'(i);
            if (cand >= (IDX_W+1)'(NREQ)) begin
                cand = cand - (IDX_W+1)'(NREQ);
            end
            if (!win_found && bus.req[cand[IDX_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IDX_W-1:0];
            end
        end
    end

    // Next-state and next-output logic for the grant / start / run / drain sequence.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        owner_d       = owner_q;
        grant_d       = grant_q;
        owner_valid_d = owner_valid_q;
        done_d        = '0;
        wd_d          = wd_q;
        // Clear first so that a watchdog set below overrides a same-cycle clear.
        timeout_d     = timeout_q & ~bus.timeout_clr;

        case (state_q)
            ST_IDLE: begin
                if (win_found && bus.startSignal__RDY) begin
                    owner_d       = win_idx;
                    grant_d       = NREQ'(1) << win_idx;
                    owner_valid_d = 1'b1;
                    ptr_d         = (win_idx == IDX_W'(NREQ - 1)) ? '0 : win_idx + IDX_W'(1);
                    state_d       = ST_START;
                end
            end
            ST_START: begin
                if (start_ena) begin
                    wd_d    = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                wd_d = wd_q + WD_W'(1);
                if (!bus.busy) begin
                    grant_d       = '0;
                    owner_valid_d = 1'b0;
                    done_d        = grant_q;
                    state_d       = ST_IDLE;
                end else if (wd_q == WD_LAST) begin
                    timeout_d     = 1'b1;
                    grant_d       = '0;
                    owner_valid_d = 1'b0;
                    done_d        = grant_q;
                    state_d       = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // A hung timer must go idle before anyone else may use it.
                if (!bus.busy) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any transfer without a done pulse.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q       <= ST_IDLE;
            ptr_q         <= '0;
            owner_q       <= '0;
            grant_q       <= '0;
            done_q        <= '0;
            owner_valid_q <= 1'b0;
            timeout_q     <= 1'b0;
            wd_q          <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            owner_q       <= owner_d;
            grant_q       <= grant_d;
            done_q        <= done_d;
            owner_valid_q <= owner_valid_d;
            timeout_q     <= timeout_d;
            wd_q          <= wd_d;
        end
    end

    assign bus.grant            = grant_q;
    assign bus.done             = done_q;
    assign bus.owner            = owner_q;
    assign bus.owner_valid      = owner_valid_q;
    assign bus.timeout          = timeout_q;
    assign bus.startSignal__ENA = start_ena;

endmodule
`default_nettype wire

// File: tb/tb_counter_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_counter_scheduler
//  Purpose  : Self-checking bench for counter_scheduler: directed scenarios
//             plus randomized requests, compared each cycle with a
//             transaction-level reference model of the scheduler.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_counter_scheduler;

    localparam int N = 4;
    localparam int W = 24;

    logic CLK = 1'b0;
    logic RST;

    counter_scheduler_if #(.NREQ(N)) bus ();

    counter_scheduler #(.NREQ(N), .WATCHDOG(W)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    // Counter environment: counter value, MAX_AMOUNT and fault forcing.
    int cnt;
    int M;
    bit f_rdy_low, f_busy, rand_mode;

    // Reference model: who owns the timer and where in its service it is.
    int         m_own, m_ptr, m_run;
    bit         m_act, m_started, m_drain, m_to;
    logic [N-1:0] m_done;

    // Observation bookkeeping.
    int cyc, ena_cnt, ena_cyc;
    logic [N-1:0] prev_grant;
    int gcnt[N];
    int dcnt[N];
    int ev_own[$];
    int ev_cyc[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic bound_fail(input string tag, input int limit);
        n_checks++;
        n_errors++;
        $display("FAIL %s: no response within %0d cycles (required within bound) at t=%0t", tag, limit, $time);
    endtask

    function automatic void model_reset();
        m_own = 0; m_ptr = 0; m_run = 0;
        m_act = 0; m_started = 0; m_drain = 0; m_to = 0;
        m_done = '0;
    endfunction

    // One clock of scheduler behaviour, from the inputs seen during the cycle.
    function automatic void model_step(logic [N-1:0] r, bit rdy, bit bsy, bit clr);
        bit set_to;
        set_to = 0;
        m_done = '0;
        if (m_drain) begin
            if (!bsy) m_drain = 0;
        end else if (m_act && !m_started) begin
            if (rdy) begin
                m_started = 1;
                m_run = 0;
            end
        end else if (m_act) begin
            if (!bsy) begin
                m_done = N'(1) << m_own;
                m_act = 0;
            end else if (m_run == W - 1) begin
                set_to = 1;
                m_done = N'(1) << m_own;
                m_act = 0;
                m_drain = 1;
            end else begin
                m_run++;
            end
        end else if (r != 0 && rdy) begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (r[c]) begin
                    m_own = c;
                    m_act = 1;
                    m_started = 0;
                    m_ptr = (c + 1) % N;
                    break;
                end
            end
        end
        if (set_to) m_to = 1;
        else if (clr) m_to = 0;
    endfunction

    task automatic env_drive();
        bus.startSignal__RDY = (cnt == 0) && !f_rdy_low;
        bus.busy             = (cnt != 0) || f_busy;
    endtask

    // Advance one clock; inputs are expected to be set already.
    task automatic cycle();
        logic [N-1:0] c_req;
        bit c_rdy, c_busy, c_clr, c_ena;
        @(negedge CLK);
        c_req  = bus.req;
        c_rdy  = bus.startSignal__RDY;
        c_busy = bus.busy;
        c_clr  = bus.timeout_clr;
        c_ena  = bus.startSignal__ENA;
        check("start_ena", 32'(c_ena), 32'(m_act && !m_started && c_rdy));
        if (c_ena) begin
            ena_cnt++;
            ena_cyc = cyc;
        end
        @(posedge CLK);
        model_step(c_req, c_rdy, c_busy, c_clr);
        if (c_ena) cnt = (rand_mode ? int'($urandom_range(1, W)) : M) - 1;
        else if (cnt > 0) cnt--;
        #1;
        cyc++;
        check("grant",       32'(bus.grant),       32'(m_act ? (N'(1) << m_own) : N'(0)));
        check("done",        32'(bus.done),        32'(m_done));
        check("owner",       32'(bus.owner),       32'(m_own));
        check("owner_valid", 32'(bus.owner_valid), 32'(m_act));
        check("timeout",     32'(bus.timeout),     32'(m_to));
        for (int i = 0; i < N; i++) begin
            if (bus.grant[i] && !prev_grant[i]) begin
                gcnt[i]++;
                ev_own.push_back(i);
                ev_cyc.push_back(cyc);
            end
            if (bus.done[i]) dcnt[i]++;
        end
        prev_grant = bus.grant;
        env_drive();
    endtask

    // Assert reset (asynchronously if called between edges) and check outputs at once.
    task automatic do_reset();
        RST = 1'b1;
        #1;
        check("rst_grant",       32'(bus.grant),            32'(0));
        check("rst_done",        32'(bus.done),             32'(0));
        check("rst_owner",       32'(bus.owner),            32'(0));
        check("rst_owner_valid", 32'(bus.owner_valid),      32'(0));
        check("rst_start_ena",   32'(bus.startSignal__ENA), 32'(0));
        check("rst_timeout",     32'(bus.timeout),          32'(0));
        model_reset();
        cnt = 0; f_rdy_low = 0; f_busy = 0;
        bus.req = '0;
        bus.timeout_clr = 1'b0;
        prev_grant = '0;
        env_drive();
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_obs();
        ev_own.delete();
        ev_cyc.delete();
        for (int i = 0; i < N; i++) begin
            gcnt[i] = 0;
            dcnt[i] = 0;
        end
        ena_cnt = 0;
        ena_cyc = -1;
        cyc = 0;
    endtask

    task automatic wait_idle(input int limit);
        int k;
        k = 0;
        while ((m_act || m_drain || bus.owner_valid) && k < limit) begin
            cycle();
            k++;
        end
        if (k >= limit) bound_fail("idle_wait", limit);
    endtask

    task automatic wait_done(input int limit, output int dc, output logic [N-1:0] dv);
        dc = -1;
        dv = '0;
        for (int k = 0; k < limit && dc < 0; k++) begin
            cycle();
            if (bus.done != 0) begin
                dc = cyc;
                dv = bus.done;
            end
        end
        if (dc < 0) bound_fail("done_wait", limit);
    endtask

    task automatic run_random(input int iters);
        for (int it = 0; it < iters; it++) begin
            logic [N-1:0] r;
            r = bus.req;
            for (int i = 0; i < N; i++) begin
                if (r[i] && bus.grant[i]) r[i] = 1'b0;
                else if (r[i] && $urandom_range(0, 39) == 0) r[i] = 1'b0;
                else if (!r[i] && !bus.grant[i] && $urandom_range(0, 5) == 0) r[i] = 1'b1;
            end
            bus.req = r;
            if (f_rdy_low) f_rdy_low = ($urandom_range(0, 2) != 0);
            else           f_rdy_low = ($urandom_range(0, 24) == 0);
            if (f_busy)    f_busy = ($urandom_range(0, 29) != 0);
            else           f_busy = ($urandom_range(0, 149) == 0);
            bus.timeout_clr = ($urandom_range(0, 9) == 0);
            env_drive();
            cycle();
        end
    endtask

    initial begin
        #400000;
        $display("FAIL global_time_limit: simulation still running at t=%0t, required to finish earlier", $time);
        $fatal(1);
    end

    initial begin
        int dc, tot_g, tot_d, to_cyc, got_regrant;
        logic [N-1:0] dv;
        int exp_own[5];
        int exp_cyc[5];
        exp_own = '{0, 1, 2, 3, 0};
        exp_cyc = '{1, 25, 49, 73, 97};

        rand_mode = 0;
        M = 22;
        cnt = 0;
        bus.req = '0;
        bus.timeout_clr = 1'b0;
        f_rdy_low = 0;
        f_busy = 0;
        env_drive();
        RST = 1'b1;
        #2;
        do_reset();

        // Single request, M=22.
        clear_obs();
        M = 22;
        bus.req = 4'b0001;
        cycle();
        bus.req = '0;
        wait_done(40, dc, dv);
        check("t1_grant_cycle", 32'(ev_cyc.size() > 0 ? ev_cyc[0] : -1), 32'(1));
        check("t1_done_cycle",  32'(dc), 32'(24));
        check("t1_done_value",  32'(dv), 32'(4'b0001));
        check("t1_ena_cycle",   32'(ena_cyc), 32'(1));
        check("t1_ena_count",   32'(ena_cnt), 32'(1));
        wait_idle(10);

        // All requesters held: round-robin order and grant spacing M+2.
        do_reset();
        clear_obs();
        bus.req = 4'b1111;
        repeat (100) cycle();
        bus.req = '0;
        wait_idle(60);
        check("t2_grant_count", 32'(ev_own.size()), 32'(5));
        for (int i = 0; i < 5; i++) begin
            if (i < ev_own.size()) begin
                check("t2_grant_owner", 32'(ev_own[i]), 32'(exp_own[i]));
                check("t2_grant_cycle", 32'(ev_cyc[i]), 32'(exp_cyc[i]));
            end
        end
        check("t2_done0", 32'(dcnt[0]), 32'(2));
        check("t2_done3", 32'(dcnt[3]), 32'(1));

        // RDY low for five cycles while in START.
        clear_obs();
        M = 3;
        bus.req = 4'b0010;
        f_rdy_low = 1;
        cycle();
        bus.req = '0;
        repeat (4) cycle();
        check("t3_grant_held", 32'(bus.grant), 32'(4'b0010));
        f_rdy_low = 0;
        wait_idle(30);
        check("t3_ena_cycle", 32'(ena_cyc), 32'(6));
        check("t3_ena_count", 32'(ena_cnt), 32'(1));

        // Busy stuck high: watchdog timeout, drain, set beats clear.
        clear_obs();
        M = 1;
        f_busy = 1;
        env_drive();
        bus.req = 4'b1000;
        cycle();
        bus.req = '0;
        to_cyc = -1;
        dv = '0;
        for (int k = 0; k < 60 && to_cyc < 0; k++) begin
            bus.timeout_clr = (cyc == 25);
            cycle();
            if (bus.timeout && to_cyc < 0) begin
                to_cyc = cyc;
                dv = bus.done;
            end
        end
        bus.timeout_clr = 1'b0;
        if (to_cyc < 0) bound_fail("t4_timeout_wait", 60);
        check("t4_timeout_cycle", 32'(to_cyc), 32'(2 + W));
        check("t4_timeout_done",  32'(dv), 32'(4'b1000));
        bus.req = 4'b0001;
        for (int k = 0; k < 5; k++) begin
            cycle();
            check("t4_no_grant_drain", 32'(bus.grant), 32'(0));
        end
        f_busy = 0;
        env_drive();
        got_regrant = 0;
        for (int k = 0; k < 10 && got_regrant == 0; k++) begin
            cycle();
            if (bus.grant[0]) got_regrant = 1;
        end
        bus.req = '0;
        check("t4_regrant", 32'(got_regrant), 32'(1));
        wait_idle(10);
        check("t4_timeout_sticky", 32'(bus.timeout), 32'(1));
        bus.timeout_clr = 1'b1;
        cycle();
        bus.timeout_clr = 1'b0;
        check("t4_timeout_cleared", 32'(bus.timeout), 32'(0));

        // Reset in the middle of RUN, then pointer back at zero.
        clear_obs();
        M = 22;
        bus.req = 4'b0001;
        cycle();
        bus.req = '0;
        repeat (8) cycle();
        #3;
        do_reset();
        M = 4;
        bus.req = 4'b0100;
        cycle();
        bus.req = '0;
        check("t5_owner", 32'(bus.owner), 32'(2));
        check("t5_grant", 32'(bus.grant), 32'(4'b0100));
        wait_idle(20);

        // One-cycle request pulse while another requester owns the timer.
        clear_obs();
        M = 10;
        bus.req = 4'b0001;
        cycle();
        bus.req = '0;
        repeat (2) cycle();
        bus.req = 4'b0100;
        cycle();
        bus.req = '0;
        wait_idle(30);
        repeat (3) cycle();
        check("t6_pulse_grant", 32'(gcnt[2]), 32'(0));
        check("t6_pulse_done",  32'(dcnt[2]), 32'(0));
        check("t6_owner_done",  32'(dcnt[0]), 32'(1));

        // Randomized traffic against the model.
        clear_obs();
        rand_mode = 1;
        run_random(2000);
        bus.req = '0;
        bus.timeout_clr = 1'b0;
        f_rdy_low = 0;
        f_busy = 0;
        env_drive();
        wait_idle(100);
        tot_g = 0;
        tot_d = 0;
        for (int i = 0; i < N; i++) begin
            tot_g += gcnt[i];
            tot_d += dcnt[i];
        end
        check("rand_one_start_per_grant", 32'(ena_cnt), 32'(tot_g));
        check("rand_one_done_per_grant",  32'(tot_d),   32'(tot_g));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
